// File: rtl/ysyx_22041752_divider.sv
// ---------------------------------------------------------------------------
// ysyx_22041752_divider
//
// Iterative radix-2 restoring divider for the EXU. It covers the RV64M
// div/divu/rem/remu instructions and their W variants. One quotient bit is
// produced per cycle: 64 iterations for a doubleword and 32 for a W op.
// Divide-by-zero and signed overflow are resolved at accept time and
// complete in a single cycle.
//
// Ports
//   clk         clock
//   reset       synchronous, active-high reset
//   div_valid   request, accepted when div_valid & div_ready & ~flush
//   div_signed  1 = div/rem/divw/remw, 0 = unsigned variants
//   div_word    1 = 32-bit W variant, 0 = 64-bit
//   dividend    rs1 value, captured on accept
//   divisor     rs2 value, captured on accept
//   flush       abort the in-flight operation
//   div_ready   idle, can accept a request
//   out_valid   one-cycle result-valid pulse (high during DONE)
//   quotient    quotient result, held until the next result is produced
//   remainder   remainder result, held until the next result is produced
// ---------------------------------------------------------------------------
module ysyx_22041752_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            div_valid,
    input  logic            div_signed,
    input  logic            div_word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            div_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    // Iteration counter; the last iteration is 31 for W ops and 63 otherwise.
    logic [6:0] cnt;

    // Datapath registers loaded on accept.
    logic [XLEN-1:0] rem_q;      // partial remainder
    logic [XLEN-1:0] sh_q;       // dividend bits shift out the top, quotient bits in the bottom
    logic [XLEN-1:0] dsr_q;      // |divisor|
    logic            quo_neg_q;
    logic            rem_neg_q;
    logic            word_q;

    // ------------------------------------------------------------------
    // Operand preparation (evaluated on the request inputs)
    // ------------------------------------------------------------------
    logic            accept;
    logic            dvd_neg, dsr_neg;
    logic [XLEN-1:0] dvd_eff, dsr_eff;
    logic [XLEN-1:0] dvd_abs, dsr_abs;
    logic [XLEN-1:0] dvd_sx32;
    logic            div_by_zero, overflow, special;
    logic [XLEN-1:0] special_quo, special_rem;

    assign div_ready = (state == IDLE);
    // Flush wins over a simultaneous request.
    assign accept    = div_valid & div_ready & ~flush;

    assign dvd_neg = div_signed & (div_word ? dividend[31] : dividend[XLEN-1]);
    assign dsr_neg = div_signed & (div_word ? divisor[31]  : divisor[XLEN-1]);

    // W operands are sign- or zero-extended from bit 31 so one 64-bit
    // negation serves both widths.
    assign dvd_eff = div_word ? {{32{dvd_neg}}, dividend[31:0]} : dividend;
    assign dsr_eff = div_word ? {{32{dsr_neg}}, divisor[31:0]}  : divisor;
    assign dvd_abs = dvd_neg ? -dvd_eff : dvd_eff;
    assign dsr_abs = dsr_neg ? -dsr_eff : dsr_eff;

    assign dvd_sx32 = {{32{dividend[31]}}, dividend[31:0]};

    assign div_by_zero = div_word ? (divisor[31:0] == 32'd0) : (divisor == '0);
    assign overflow    = div_signed &
                         (div_word ? ((dividend[31:0] == 32'h8000_0000) & (&divisor[31:0]))
                                   : ((dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor)));
    assign special     = div_by_zero | overflow;

    // Divide-by-zero takes priority over overflow. For overflow the
    // quotient equals the (sign-extended) dividend, which dvd_eff already is.
    assign special_quo = div_by_zero ? {XLEN{1'b1}} : dvd_eff;
    assign special_rem = div_by_zero ? (div_word ? dvd_sx32 : dividend) : '0;

    // ------------------------------------------------------------------
    // One restoring iteration
    // ------------------------------------------------------------------
    logic [XLEN:0]   partial;
    logic            q_bit;
    logic [XLEN-1:0] rem_nxt, sh_nxt;
    logic            last_iter;
    logic [XLEN-1:0] q_signed, r_signed;
    logic [XLEN-1:0] q_final, r_final;

    assign partial = {rem_q, sh_q[XLEN-1]} - {1'b0, dsr_q};
    assign q_bit   = ~partial[XLEN];
    // When the subtraction is negative, {rem, bit} < |divisor| and so its
    // top bit is zero; dropping rem_q[XLEN-1] loses nothing.
    assign rem_nxt = q_bit ? partial[XLEN-1:0] : {rem_q[XLEN-2:0], sh_q[XLEN-1]};
    assign sh_nxt  = {sh_q[XLEN-2:0], q_bit};

    assign last_iter = (state == CALC) && (cnt == (word_q ? 7'd31 : 7'd63));

    // Sign fix-up; the low 32 bits of a 64-bit negation equal the 32-bit
    // negation, so W results just sign-extend bit 31 afterwards.
    assign q_signed = quo_neg_q ? -sh_nxt  : sh_nxt;
    assign r_signed = rem_neg_q ? -rem_nxt : rem_nxt;
    assign q_final  = word_q ? {{32{q_signed[31]}}, q_signed[31:0]} : q_signed;
    assign r_final  = word_q ? {{32{r_signed[31]}}, r_signed[31:0]} : r_signed;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned; otherwise a latch would be inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) next_state = special ? DONE : CALC;
            end
            CALC: begin
                if (flush)          next_state = IDLE;
                else if (last_iter) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // out_valid is registered from the next state so it is high exactly
    // while the FSM sits in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            out_valid <= (next_state == DONE);
            if (accept || state != CALC) cnt <= '0;
            else                         cnt <= cnt + 7'd1;
        end
    end

    // Result registers change only when a result is produced, so the EXU
    // may sample them any time before the next DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (accept && special) begin
            quotient  <= special_quo;
            remainder <= special_rem;
        end else if (last_iter && !flush) begin
            quotient  <= q_final;
            remainder <= r_final;
        end
    end

    // NOTE: the working datapath has no reset; every field is loaded on
    // accept before it is read, and leaving it out keeps reset fan-out low.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q     <= '0;
            // W dividends are left-aligned so the first bit shifted out is bit 31.
            sh_q      <= div_word ? {dvd_abs[31:0], 32'd0} : dvd_abs;
            dsr_q     <= dsr_abs;
            quo_neg_q <= dvd_neg ^ dsr_neg;
            rem_neg_q <= dvd_neg;
            word_q    <= div_word;
        end else if (state == CALC) begin
            rem_q <= rem_nxt;
            sh_q  <= sh_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_22041752_divider.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041752_divider
//
// Self-checking bench for ysyx_22041752_divider: a table of hand-computed
// vectors, hand-written flush/reset sequences, and randomized operations
// compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_ysyx_22041752_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_valid, div_signed, div_word, flush;
    logic [63:0] dividend, divisor;
    logic        div_ready, out_valid;
    logic [63:0] quotient, remainder;

    ysyx_22041752_divider #(.XLEN(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_signed (div_signed),
        .div_word   (div_word),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .div_ready  (div_ready),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Reference model: RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [127:0] ref_div(input logic sgn, input logic word,
                                             input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, q32, r32;
        logic [63:0] q, r;
        a32 = a[31:0];
        b32 = b[31:0];
        if (word) begin
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = '1; r = a;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 64'd0;
            end else if (sgn) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
        return {q, r};
    endfunction

    function automatic int ref_lat(input logic sgn, input logic word,
                                   input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        zero = word ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = sgn && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (zero || ovf) return 1;
        return word ? 33 : 65;
    endfunction

    // Issue one request and wait (bounded) for out_valid. lat counts cycles
    // from the accept edge (1 = out_valid visible right after that edge).
    task automatic do_op(input logic sgn, input logic word, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r,
                         output int lat, output bit ready_low);
        int w;
        w = 0;
        @(negedge clk);
        while (!div_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", {63'd0, div_ready}, 64'd1);
        div_valid  = 1'b1;
        div_signed = sgn;
        div_word   = word;
        dividend   = a;
        divisor    = b;
        @(posedge clk);
        #1;
        div_valid  = 1'b0;
        dividend   = {$urandom, $urandom};
        divisor    = {$urandom, $urandom};
        div_signed = 1'($urandom);
        div_word   = 1'($urandom);
        lat        = 1;
        ready_low  = 1'b1;
        while (!out_valid && lat < 200) begin
            if (div_ready) ready_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (div_ready) ready_low = 1'b0;
        q = quotient;
        r = remainder;
    endtask

    typedef struct {
        logic        sgn;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [63:0] q, r, a, b;
        logic [127:0] exp_qr;
        int          lat, pulses;
        bit          ready_low;
        logic        sgn, word;

        vecs[0]  = '{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65};
        vecs[1]  = '{1'b1, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        vecs[2]  = '{1'b1, 1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65};
        vecs[3]  = '{1'b0, 1'b1, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 64'd0, 33};
        vecs[4]  = '{1'b1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1};
        vecs[5]  = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 64'd0, 1};
        vecs[6]  = '{1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFF_8000_0000, 64'd0, 1};
        vecs[7]  = '{1'b0, 1'b1, 64'h0000_0000_9000_0001, 64'h0000_0001_0000_0000,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_9000_0001, 1};
        vecs[8]  = '{1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[9]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};
        vecs[10] = '{1'b0, 1'b0, 64'd5, 64'd7, 64'd0, 64'd5, 65};

        reset = 1'b1; div_valid = 1'b0; div_signed = 1'b0; div_word = 1'b0;
        flush = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",     {63'd0, div_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_quotient",  quotient,  64'd0);
        check("reset_remainder", remainder, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven directed vectors.
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].sgn, vecs[i].word, vecs[i].a, vecs[i].b, q, r, lat, ready_low);
            check($sformatf("vec%0d_quotient", i),  q, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d_latency", i),   64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_ready_low", i), {63'd0, ready_low}, 64'd1);
        end

        // Result holds after out_valid until the next result.
        do_op(1'b0, 1'b0, 64'd100, 64'd7, q, r, lat, ready_low);
        repeat (5) @(posedge clk);
        #1;
        check("hold_quotient",  quotient,  64'd14);
        check("hold_remainder", remainder, 64'd2);

        // Flush at CALC cycle 10.
        @(negedge clk);
        div_valid = 1'b1; div_signed = 1'b0; div_word = 1'b0;
        dividend = 64'd1000; divisor = 64'd3;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        pulses = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_ready",     {63'd0, div_ready}, 64'd1);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_pulses",    64'(pulses), 64'd0);
        check("flush_quotient",  quotient,  64'd14);
        check("flush_remainder", remainder, 64'd2);
        do_op(1'b0, 1'b0, 64'd9, 64'd3, q, r, lat, ready_low);
        check("after_flush_quotient",  q, 64'd3);
        check("after_flush_remainder", r, 64'd0);
        check("after_flush_latency",   64'(lat), 64'd65);

        // Flush while idle with a request present: no accept.
        @(negedge clk);
        div_valid = 1'b1; flush = 1'b1; dividend = 64'd50; divisor = 64'd5;
        @(posedge clk);
        #1;
        div_valid = 1'b0; flush = 1'b0;
        check("idle_flush_ready", {63'd0, div_ready}, 64'd1);
        check("idle_flush_quotient", quotient, 64'd3);

        // Flush during DONE: the pulse still appears.
        @(negedge clk);
        div_valid = 1'b1; div_signed = 1'b1; div_word = 1'b0;
        dividend = 64'd11; divisor = 64'd0;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        flush = 1'b1;
        check("done_flush_out_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("done_flush_idle", {63'd0, div_ready}, 64'd1);
        check("done_flush_quotient", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        check("done_flush_remainder", remainder, 64'd11);

        // Reset at CALC cycle 20.
        @(negedge clk);
        div_valid = 1'b1; div_signed = 1'b1; div_word = 1'b0;
        dividend = 64'd12345; divisor = 64'd17;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_ready",     {63'd0, div_ready}, 64'd1);
        check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        check("midreset_quotient",  quotient,  64'd0);
        check("midreset_remainder", remainder, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("midreset_no_pulse", 64'(pulses), 64'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            sgn  = 1'($urandom);
            word = 1'($urandom);
            case ($urandom_range(0, 4))
                0:       a = 64'h8000_0000_0000_0000;
                1:       a = {32'($urandom), 32'h8000_0000};
                2:       a = 64'($urandom_range(0, 100));
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 7))
                0:       b = 64'd0;
                1:       b = '1;
                2:       b = {32'($urandom), 32'd0};
                3:       b = 64'($urandom_range(1, 15));
                4:       b = -64'($urandom_range(1, 15));
                default: b = {$urandom, $urandom} >> $urandom_range(0, 62);
            endcase
            exp_qr = ref_div(sgn, word, a, b);
            do_op(sgn, word, a, b, q, r, lat, ready_low);
            check($sformatf("rnd%0d_quotient s=%0d w=%0d a=%h b=%h", i, sgn, word, a, b), q, exp_qr[127:64]);
            check($sformatf("rnd%0d_remainder s=%0d w=%0d a=%h b=%h", i, sgn, word, a, b), r, exp_qr[63:0]);
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(ref_lat(sgn, word, a, b)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_22041752_divider.md
Name: ysyx_22041752_divider

Overview:
- Iterative radix-2 restoring divider serving the EXU for RV64M div/divu/rem/remu and the W variants (divw/divuw/remw/remuw).
- Sits beside the EXU. The EXU issues operands and stalls the pipeline (es_allowin low) until the result returns.
- Result feeds the EXU's div_result path.
- Single-cycle completion for divide-by-zero and signed overflow.

Parameters:
- XLEN, 64, datapath width; the only supported value is 64.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- div_valid  in  1  operation request, qualified by div_ready
- div_signed  in  1  1 = signed (div/rem/divw/remw), 0 = unsigned
- div_word  in  1  1 = 32-bit W variant, 0 = 64-bit
- dividend  in  64  rs1 value
- divisor  in  64  rs2 value
- flush  in  1  abort the in-flight operation (EXU cancel)
- div_ready  out  1  idle, can accept a request
- out_valid  out  1  one-cycle result-valid pulse
- quotient  out  64  quotient result
- remainder  out  64  remainder result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - div_ready = 1
  - out_valid = 0
  - quotient = 0
  - remainder = 0
  - internal counter = 0
- Handshake: a request is accepted on a rising edge where div_valid & div_ready. Operands are captured that cycle. Inputs are ignored at all other times.
- State machine:
  - IDLE: div_ready = 1.
    - Accept with a special case -> DONE.
    - Accept with no special case -> CALC.
  - CALC: N iterations, one per cycle, where N = 32 if div_word else 64. After the N-th iteration -> DONE.
  - DONE: out_valid = 1 for exactly one cycle, then -> IDLE.
- out_valid is registered. It is never high while div_ready = 1, except that the DONE cycle and the next accept are distinct cycles.
- Latency, accept edge to out_valid high:
  - 64-bit: 65 cycles.
  - W: 33 cycles.
  - Special case: 1 cycle.
- Back-to-back: the next accept is possible the cycle after DONE.
- Operand preparation:
  - W ops use dividend[31:0] and divisor[31:0].
  - Signed ops take absolute values. Quotient sign = sign(dividend) XOR sign(divisor). Remainder sign = sign(dividend).
  - The final negation is applied at the CALC -> DONE transition.
- Iteration, each cycle:
  - partial = {rem, next dividend bit} - |divisor|.
  - If partial is non-negative: rem = partial and the quotient bit = 1.
  - Otherwise rem is kept and the quotient bit = 0.
  - A 65-bit subtractor is used.
- W result formatting: quotient and remainder are sign-extended from bit 31. This applies to divuw/remuw too.
- Special cases, detected at accept:
  - Divisor zero (of the effective width): quotient = all ones (64'hFFFF_FFFF_FFFF_FFFF; for W, sext(32'hFFFF_FFFF)). Remainder = dividend, sext'd from bit 31 for W.
  - Signed overflow: dividend = most-negative value of the width and divisor = -1. Quotient = dividend (W: sext(32'h8000_0000)). Remainder = 0.
  - Divide-by-zero takes priority over overflow.
- Output hold: quotient and remainder are stable from the DONE cycle until the next accepted request's DONE. The EXU may sample them late.
- Flush:
  - In CALC: the next state is IDLE and no out_valid is produced. Outputs keep their previous values.
  - In DONE: out_valid is still pulsed, and the EXU ignores it.
  - In IDLE while div_valid is high: flush takes priority and no accept occurs.
- Reset mid-operation: returns to IDLE next edge, outputs cleared, no out_valid.
- div_valid held high after out_valid is a new request. The EXU must drop it on the out_valid cycle.

Test Plan:
- divu 64-bit: 100 / 7 -> out_valid exactly 65 cycles after accept, quotient = 14, remainder = 2, div_ready low for 65 cycles.
- div signed 64-bit: -7 / 2 -> quotient = -3 (0xFFFF_FFFF_FFFF_FFFD), remainder = -1. Also 7 / -2 -> quotient = -3, remainder = 1.
- divuw: dividend 0x0000_0001_8000_0000, divisor 1 -> quotient = 0xFFFF_FFFF_8000_0000 (sign-extended), remainder = 0, latency 33.
- Special cases, all with 1-cycle latency:
  - div x / 0 with x = 5 -> quotient = all ones, remainder = 5.
  - div 0x8000_0000_0000_0000 / -1 -> quotient = 0x8000_0000_0000_0000, remainder = 0.
  - divw 0x8000_0000 / -1 -> quotient = 0xFFFF_FFFF_8000_0000, remainder = 0.
- Flush at CALC cycle 10 -> no out_valid, div_ready high next cycle. A new request 9 / 3 then gives quotient = 3, remainder = 0.
- Reset asserted at CALC cycle 20 -> next cycle: state IDLE, quotient = 0, remainder = 0, out_valid = 0. Random signed/unsigned, word/dword ops are compared against a reference model.
